serial_adder: RTL and testbench

//  Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock.

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 16 +
 rtl/serial_adder.sv | 171 +++++++++++++++++
 tb/tb_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// counter sizing helper.
package serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // One extra bit over $clog2 so the counter can represent WIDTH-1 even for WIDTH=1.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Gate-level one-bit full adder used as the arithmetic cell of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic ab_x_s;

  assign ab_x_s = a ^ b;
  assign sum    = ab_x_s ^ c;
  assign carry  = (a & b) | (c & ab_x_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock, start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             load_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_s;
  logic             fa_sum_s;
  logic             fa_co_s;

  full_adder u_fa (
    .a     (a_sr_r[0]),
    .b     (b_sr_r[0]),
    .c     (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_co_s)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // The new sum bit enters the accumulator MSB; a 1-bit accumulator is just the bit.
  generate
    if (WIDTH == 1) begin : g_acc_one
      assign acc_nxt_s = fa_sum_s;
    end else begin : g_acc_wide
      assign acc_nxt_s = {fa_sum_s, acc_r[WIDTH-1:1]};
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; start is honoured only outside SHIFT
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        load_s      = 1'b0;
      end
    endcase
  end

  // FSM output decode from the upcoming state so busy/done can be registered
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_SHIFT: busy_nxt_s = 1'b1;
      ST_DONE:  done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt_s;
      done <= done_nxt_s;
    end
  end

  // Operand shift registers, carry loop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (load_s) begin
      a_sr_r  <= a;
      b_sr_r  <= b;
      carry_r <= cin;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (state_r == ST_SHIFT) begin
      a_sr_r  <= a_sr_r >> 1'b1;
      b_sr_r  <= b_sr_r >> 1'b1;
      acc_r   <= acc_nxt_s;
      carry_r <= fa_co_s;
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  // Result registers, updated only on the final shift edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= {WIDTH{1'b0}};
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if ((state_r == ST_SHIFT) && last_s) begin
      sum  <= acc_nxt_s;
      cout <= fa_co_s;
`ifdef SERIAL_ADDER_OVF_EN
      // Carry into the MSB differs from carry out of it exactly on signed overflow.
      ovf  <= carry_r ^ fa_co_s;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances),
// compared against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;
  logic       ovf1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: {ovf, cout, sum[7:0]} from plain integer addition.
  function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full add on the WIDTH=8 instance, entered and left in IDLE.
  task automatic do_add(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input string tag);
    int         n;
    logic [9:0] e;
    logic [7:0] prev;
    e     = ref_add(xa, xb, xc);
    prev  = sum;
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    n     = 0;
    while (!done && n < 20) begin
      if (n == 4) begin
        check({tag, ":hold"}, 32'(sum), 32'(prev));
        check({tag, ":busy"}, 32'(busy), 32'd1);
      end
      tick();
      n++;
    end
    check({tag, ":lat"}, n, 8);
    check({tag, ":sum"}, 32'(sum), 32'(e[7:0]));
    check({tag, ":cout"}, 32'(cout), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ":ovf"}, 32'(ovf), 32'(e[9]));
`endif
    check({tag, ":busy_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, ":pulse"}, 32'(done), 32'd0);
  endtask

  // One add on the WIDTH=1 instance.
  task automatic do_add1(input logic xa, input logic xb, input logic xc, input string tag);
    int         n;
    logic [1:0] t;
    t      = 2'(xa) + 2'(xb) + 2'(xc);
    a1     = xa;
    b1     = xb;
    cin1   = xc;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n      = 0;
    while (!done1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, ":lat"}, n, 1);
    check({tag, ":sum"}, 32'(sum1), 32'(t[0]));
    check({tag, ":cout"}, 32'(cout1), 32'(t[1]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ":ovf"}, 32'(ovf1), 32'((xa == xb) && (t[0] != xa)));
`endif
    tick();
    check({tag, ":pulse"}, 32'(done1), 32'd0);
  endtask

  initial begin
    int   np;
    int   cyc;
    int   t0;
    int   t1;
    logic [7:0] s0;
    logic [7:0] s1;
    logic busy_after;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:sum", 32'(sum), 32'd0);
    check("rst:cout", 32'(cout), 32'd0);
    check("rst:ovf", 32'(ovf), 32'd0);
    check("rst1:busy", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed operand cases
    do_add(8'h5A, 8'h3C, 1'b0, "t1");
    do_add(8'hFF, 8'h01, 1'b0, "t2a");
    do_add(8'h00, 8'h00, 1'b1, "t2b");

    // Second start during SHIFT is ignored
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    np    = 0;
    s0    = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        np++;
        s0 = sum;
      end
      tick();
    end
    check("t3:npulse", np, 1);
    check("t3:sum", 32'(s0), 32'h30);

    // Back-to-back with start held high
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    a          = 8'h02;
    b          = 8'h02;
    np         = 0;
    cyc        = 0;
    t0         = 0;
    t1         = 0;
    s0         = 8'h00;
    s1         = 8'h00;
    busy_after = 1'b0;
    while (np < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (np == 1 && cyc == t0 + 1) busy_after = busy;
      if (done) begin
        if (np == 0) begin
          t0 = cyc;
          s0 = sum;
        end else begin
          t1 = cyc;
          s1 = sum;
          start = 1'b0;
        end
        np++;
      end
    end
    start = 1'b0;
    check("t4:npulse", np, 2);
    check("t4:gap", t1 - t0, 9);
    check("t4:sum0", 32'(s0), 32'h02);
    check("t4:sum1", 32'(s1), 32'h04);
    check("t4:no_idle", 32'(busy_after), 32'd1);
    tick();

    // Reset in the middle of an operation
    a     = 8'h7F;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t5:busy", 32'(busy), 32'd0);
    check("t5:done", 32'(done), 32'd0);
    check("t5:sum", 32'(sum), 32'd0);
    check("t5:cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    np    = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) np++;
    end
    check("t5:no_done", np, 0);
    do_add(8'h7F, 8'h01, 1'b0, "t5b");

    // Randomized adds against the model
    for (int i = 0; i < 20; i++) begin
      do_add(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    // WIDTH=1 instance: all operand combinations
    do_add1(1'b1, 1'b1, 1'b1, "t6");
    for (int i = 0; i < 8; i++) begin
      do_add1(i[2], i[1], i[0], $sformatf("w1_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
